jb_ul_dfe_ctrl_shadow: RTL and testbench

Register-side producer for the UL DFE control bundle (carrier NCO, stream/antenna gains, integer/fractional delays, delay trigger). Software writes a shadow bank over a simple word-addressed register bus. The shadow bank is copied atomically into the active bank, which drives the UL DFE, either on the next frame_sync after arming or immediately on command. The block sits directly upstream of the UL DFE datapath and drives its control modport.

---
 rtl/jb_ul_dfe_ctrl_shadow.sv | 209 ++++++++++++++++++++
 tb/tb_jb_ul_dfe_ctrl_shadow.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jb_ul_dfe_ctrl_shadow.sv
// UL DFE control register block: software-written shadow bank copied atomically
// into the active bank on the next frame_sync after arming or on commit_now.
module jb_ul_dfe_ctrl_shadow #(
  parameter int unsigned ADDR_W             = 8,
  parameter bit          DLY_TRIG_ON_COMMIT = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    reg_wr_en,
  input  logic                    reg_rd_en,
  input  logic [ADDR_W-1:0]       reg_addr,
  input  logic [31:0]             reg_wr_data,
  output logic [31:0]             reg_rd_data,
  output logic                    reg_rd_valid,
  input  logic                    frame_sync,
  output logic                    ul_ant_int_frac_delay_trig,
  output logic [1:0][31:0]        ul_car_nco_lsb,
  output logic [1:0][7:0]         ul_car_nco_msb,
  output logic [1:0]              ul_car_nco_sign,
  output logic [1:0][3:0]         ul_stream_gain_scaler_sign,
  output logic [1:0][3:0][3:0]    ul_stream_gain_scaler,
  output logic [1:0][3:0][15:0]   ul_stream_gain_fraction,
  output logic [3:0]              ul_ant_gain_scaler_sign,
  output logic [3:0][3:0]         ul_ant_gain_scaler,
  output logic [3:0][15:0]        ul_ant_gain_fraction,
  output logic [1:0][3:0][6:0]    ul_int_delay,
  output logic [1:0][3:0][15:0]   ul_frac_delay,
  output logic                    armed
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ARMED = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [1:0][31:0]      sh_lsb;
  logic [1:0][7:0]       sh_msb;
  logic [1:0]            sh_sign;
  logic [1:0][3:0]       sh_sg_sign;
  logic [1:0][3:0][3:0]  sh_sg_scl;
  logic [1:0][3:0][15:0] sh_sg_frac;
  logic [3:0]            sh_ag_sign;
  logic [3:0][3:0]       sh_ag_scl;
  logic [3:0][15:0]      sh_ag_frac;
  logic [1:0][3:0][6:0]  sh_int;
  logic [1:0][3:0][15:0] sh_frac;

  logic [7:0]  commit_cnt;
  logic        dly_dirty;
  logic        trig_pend;

  logic        hit_c;
  logic [5:0]  word_c;
  logic        wr_c;
  logic        rd_c;
  logic        ctrl_wr_c;
  logic        arm_c;
  logic        commit_now_c;
  logic        force_trig_c;
  logic        dly_wr_c;
  logic        commit_c;
  logic [31:0] rd_data_c;

  // Only the low 6 address bits decode; anything above must be zero.
  assign hit_c        = (reg_addr >> 6) == '0;
  assign word_c       = reg_addr[5:0];
  assign wr_c         = reg_wr_en & hit_c;
  assign rd_c         = reg_rd_en & ~reg_wr_en;
  assign ctrl_wr_c    = wr_c & (word_c == 6'h00);
  assign arm_c        = ctrl_wr_c & reg_wr_data[0];
  assign commit_now_c = ctrl_wr_c & reg_wr_data[1];
  assign force_trig_c = ctrl_wr_c & reg_wr_data[2];
  assign dly_wr_c     = wr_c & (word_c[5:3] == 3'b011);
  assign armed        = (state_q == S_ARMED);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // commit_now beats arm; frame_sync only counts once already armed.
  always_comb begin
    state_d  = state_q;
    commit_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (commit_now_c)  commit_c = 1'b1;
        else if (arm_c)    state_d  = S_ARMED;
      end
      S_ARMED: begin
        if (commit_now_c || frame_sync) begin
          commit_c = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_lsb     <= '0;
      sh_msb     <= '0;
      sh_sign    <= '0;
      sh_sg_sign <= '0;
      sh_sg_scl  <= '0;
      sh_sg_frac <= '0;
      sh_ag_sign <= '0;
      sh_ag_scl  <= '0;
      sh_ag_frac <= '0;
      sh_int     <= '0;
      sh_frac    <= '0;
    end else if (wr_c) begin
      if (word_c[5:1] == 5'b00001) begin
        sh_lsb[word_c[0]] <= reg_wr_data;
      end else if (word_c[5:1] == 5'b00010) begin
        sh_msb[word_c[0]]  <= reg_wr_data[7:0];
        sh_sign[word_c[0]] <= reg_wr_data[8];
      end else if (word_c[5:3] == 3'b001) begin
        sh_sg_frac[word_c[2]][word_c[1:0]] <= reg_wr_data[15:0];
        sh_sg_scl[word_c[2]][word_c[1:0]]  <= reg_wr_data[19:16];
        sh_sg_sign[word_c[2]][word_c[1:0]] <= reg_wr_data[20];
      end else if (word_c[5:2] == 4'b0100) begin
        sh_ag_frac[word_c[1:0]] <= reg_wr_data[15:0];
        sh_ag_scl[word_c[1:0]]  <= reg_wr_data[19:16];
        sh_ag_sign[word_c[1:0]] <= reg_wr_data[20];
      end else if (word_c[5:3] == 3'b011) begin
        sh_frac[word_c[2]][word_c[1:0]] <= reg_wr_data[15:0];
        sh_int[word_c[2]][word_c[1:0]]  <= reg_wr_data[22:16];
      end
    end
  end

  always_comb begin
    rd_data_c = '0;
    if (hit_c) begin
      casez (word_c)
        6'h01:     rd_data_c = {16'd0, commit_cnt, 7'd0, armed};
        6'b00001?: rd_data_c = sh_lsb[word_c[0]];
        6'b00010?: rd_data_c = {23'd0, sh_sign[word_c[0]], sh_msb[word_c[0]]};
        6'b001???: rd_data_c = {11'd0, sh_sg_sign[word_c[2]][word_c[1:0]],
                                sh_sg_scl[word_c[2]][word_c[1:0]],
                                sh_sg_frac[word_c[2]][word_c[1:0]]};
        6'b0100??: rd_data_c = {11'd0, sh_ag_sign[word_c[1:0]],
                                sh_ag_scl[word_c[1:0]], sh_ag_frac[word_c[1:0]]};
        6'b011???: rd_data_c = {9'd0, sh_int[word_c[2]][word_c[1:0]],
                                sh_frac[word_c[2]][word_c[1:0]]};
        default:   rd_data_c = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_rd_valid <= 1'b0;
      reg_rd_data  <= '0;
    end else begin
      reg_rd_valid <= rd_c;
      if (rd_c) reg_rd_data <= rd_data_c;
    end
  end

  // Active bank is the output register set itself, so it only moves on commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      ul_car_nco_lsb             <= '0;
      ul_car_nco_msb             <= '0;
      ul_car_nco_sign            <= '0;
      ul_stream_gain_scaler_sign <= '0;
      ul_stream_gain_scaler      <= '0;
      ul_stream_gain_fraction    <= '0;
      ul_ant_gain_scaler_sign    <= '0;
      ul_ant_gain_scaler         <= '0;
      ul_ant_gain_fraction       <= '0;
      ul_int_delay               <= '0;
      ul_frac_delay              <= '0;
    end else if (commit_c) begin
      ul_car_nco_lsb             <= sh_lsb;
      ul_car_nco_msb             <= sh_msb;
      ul_car_nco_sign            <= sh_sign;
      ul_stream_gain_scaler_sign <= sh_sg_sign;
      ul_stream_gain_scaler      <= sh_sg_scl;
      ul_stream_gain_fraction    <= sh_sg_frac;
      ul_ant_gain_scaler_sign    <= sh_ag_sign;
      ul_ant_gain_scaler         <= sh_ag_scl;
      ul_ant_gain_fraction       <= sh_ag_frac;
      ul_int_delay               <= sh_int;
      ul_frac_delay              <= sh_frac;
    end
  end

  // Trigger trails the active update by one cycle; back-to-back requests merge.
  always_ff @(posedge clk) begin
    if (rst) begin
      commit_cnt                 <= '0;
      dly_dirty                  <= 1'b0;
      trig_pend                  <= 1'b0;
      ul_ant_int_frac_delay_trig <= 1'b0;
    end else begin
      if (commit_c) commit_cnt <= commit_cnt + 8'd1;
      dly_dirty                  <= (dly_dirty & ~commit_c) | dly_wr_c;
      trig_pend                  <= commit_c & dly_dirty & DLY_TRIG_ON_COMMIT;
      ul_ant_int_frac_delay_trig <= (trig_pend | force_trig_c) & ~ul_ant_int_frac_delay_trig;
    end
  end

endmodule

// File: tb/tb_jb_ul_dfe_ctrl_shadow.sv
// Randomized scoreboard bench for jb_ul_dfe_ctrl_shadow against a word-level
// register model with per-cycle expected events.
module tb_jb_ul_dfe_ctrl_shadow;

  localparam int unsigned ADDR_W = 8;
  localparam bit          DLY    = 1'b1;
  localparam int unsigned SNAP_W = 519;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  reg_wr_en = 1'b0;
  logic                  reg_rd_en = 1'b0;
  logic [ADDR_W-1:0]     reg_addr = '0;
  logic [31:0]           reg_wr_data = '0;
  logic [31:0]           reg_rd_data;
  logic                  reg_rd_valid;
  logic                  frame_sync = 1'b0;
  logic                  ul_ant_int_frac_delay_trig;
  logic [1:0][31:0]      ul_car_nco_lsb;
  logic [1:0][7:0]       ul_car_nco_msb;
  logic [1:0]            ul_car_nco_sign;
  logic [1:0][3:0]       ul_stream_gain_scaler_sign;
  logic [1:0][3:0][3:0]  ul_stream_gain_scaler;
  logic [1:0][3:0][15:0] ul_stream_gain_fraction;
  logic [3:0]            ul_ant_gain_scaler_sign;
  logic [3:0][3:0]       ul_ant_gain_scaler;
  logic [3:0][15:0]      ul_ant_gain_fraction;
  logic [1:0][3:0][6:0]  ul_int_delay;
  logic [1:0][3:0][15:0] ul_frac_delay;
  logic                  armed;

  jb_ul_dfe_ctrl_shadow #(.ADDR_W(ADDR_W), .DLY_TRIG_ON_COMMIT(DLY)) dut (
    .clk(clk), .rst(rst),
    .reg_wr_en(reg_wr_en), .reg_rd_en(reg_rd_en), .reg_addr(reg_addr),
    .reg_wr_data(reg_wr_data), .reg_rd_data(reg_rd_data), .reg_rd_valid(reg_rd_valid),
    .frame_sync(frame_sync), .ul_ant_int_frac_delay_trig(ul_ant_int_frac_delay_trig),
    .ul_car_nco_lsb(ul_car_nco_lsb), .ul_car_nco_msb(ul_car_nco_msb),
    .ul_car_nco_sign(ul_car_nco_sign),
    .ul_stream_gain_scaler_sign(ul_stream_gain_scaler_sign),
    .ul_stream_gain_scaler(ul_stream_gain_scaler),
    .ul_stream_gain_fraction(ul_stream_gain_fraction),
    .ul_ant_gain_scaler_sign(ul_ant_gain_scaler_sign),
    .ul_ant_gain_scaler(ul_ant_gain_scaler),
    .ul_ant_gain_fraction(ul_ant_gain_fraction),
    .ul_int_delay(ul_int_delay), .ul_frac_delay(ul_frac_delay), .armed(armed)
  );

  always #5 clk = ~clk;

  int cnt = 0;
  always @(posedge clk) cnt <= cnt + 1;

  typedef struct { int cyc; logic [31:0] d; } rd_item_t;
  typedef struct { int cyc; logic [SNAP_W-1:0] v; } snap_item_t;

  rd_item_t   rd_q[$];
  snap_item_t snap_q[$];
  int         trig_q[$];

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Reference model: plain word arrays plus pending trigger requests per cycle.
  logic [31:0] m_sh  [64];
  logic [31:0] m_act [64];
  bit          m_armed;
  logic [7:0]  m_cnt;
  bit          m_dirty;
  bit          req[int];
  bit          exp_trig[int];

  function automatic logic [31:0] mask_of(input int w);
    if (w == 2 || w == 3)   return 32'hFFFF_FFFF;
    if (w == 4 || w == 5)   return 32'h0000_01FF;
    if (w >= 8 && w < 20)   return 32'h001F_FFFF;
    if (w >= 24 && w < 32)  return 32'h007F_FFFF;
    return 32'h0;
  endfunction

  function automatic logic [SNAP_W-1:0] mk_snap();
    logic [1:0][31:0]      lsb;
    logic [1:0][7:0]       msb;
    logic [1:0]            sgn;
    logic [1:0][3:0]       sgs;
    logic [1:0][3:0][3:0]  sgc;
    logic [1:0][3:0][15:0] sgf;
    logic [3:0]            ags;
    logic [3:0][3:0]       agc;
    logic [3:0][15:0]      agf;
    logic [1:0][3:0][6:0]  idl;
    logic [1:0][3:0][15:0] fdl;
    logic [31:0]           w;
    for (int c = 0; c < 2; c++) begin
      lsb[c] = m_act[2+c];
      w      = m_act[4+c];
      msb[c] = w[7:0];
      sgn[c] = w[8];
    end
    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < 4; a++) begin
        w = m_act[8+4*s+a];
        sgf[s][a] = w[15:0]; sgc[s][a] = w[19:16]; sgs[s][a] = w[20];
        w = m_act[24+4*s+a];
        fdl[s][a] = w[15:0]; idl[s][a] = w[22:16];
      end
    end
    for (int a = 0; a < 4; a++) begin
      w = m_act[16+a];
      agf[a] = w[15:0]; agc[a] = w[19:16]; ags[a] = w[20];
    end
    return {m_armed, lsb, msb, sgn, sgs, sgc, sgf, ags, agc, agf, idl, fdl};
  endfunction

  task automatic push_snap(input int c);
    snap_item_t it;
    it.cyc = c;
    it.v   = mk_snap();
    snap_q.push_back(it);
  endtask

  // Inputs presented in cycle k: register effects show at k+1, commit trigger at k+2.
  task automatic model_step(input int k, input bit r, input bit we, input bit re,
                            input logic [ADDR_W-1:0] a, input logic [31:0] d, input bit fs);
    bit hit, arm, cn, frc, commit, changed;
    int w;
    rd_item_t ri;
    if (r) begin
      for (int i = 0; i < 64; i++) begin m_sh[i] = '0; m_act[i] = '0; end
      m_armed = 1'b0; m_cnt = '0; m_dirty = 1'b0;
      for (int i = rd_q.size() - 1; i >= 0; i--) if (rd_q[i].cyc > k) rd_q.delete(i);
      for (int i = trig_q.size() - 1; i >= 0; i--) if (trig_q[i] > k) trig_q.delete(i);
      if (req.exists(k+1)) req.delete(k+1);
      if (req.exists(k+2)) req.delete(k+2);
      exp_trig[k+1] = 1'b0;
      push_snap(k+1);
      return;
    end
    hit = (a >> 6) == 0;
    w   = int'(a[5:0]);
    if (re && !we) begin
      ri.cyc = k + 1;
      if (!hit)        ri.d = '0;
      else if (w == 1) ri.d = {16'd0, m_cnt, 7'd0, m_armed};
      else             ri.d = m_sh[w];
      rd_q.push_back(ri);
    end
    arm = we && hit && w == 0 && d[0];
    cn  = we && hit && w == 0 && d[1];
    frc = we && hit && w == 0 && d[2];
    commit  = cn || (m_armed && fs);
    changed = 1'b0;
    if (commit) begin
      for (int i = 0; i < 64; i++) m_act[i] = m_sh[i];
      m_cnt = m_cnt + 8'd1;
      if (DLY && m_dirty) req[k+2] = 1'b1;
      m_dirty = 1'b0;
      m_armed = 1'b0;
      changed = 1'b1;
    end else if (arm && !m_armed) begin
      m_armed = 1'b1;
      changed = 1'b1;
    end
    if (we && hit && mask_of(w) != 0) begin
      m_sh[w] = d & mask_of(w);
      if (w >= 24) m_dirty = 1'b1;
    end
    if (frc) req[k+1] = 1'b1;
    exp_trig[k+1] = req.exists(k+1) && !(exp_trig.exists(k) && exp_trig[k]);
    if (exp_trig[k+1]) trig_q.push_back(k+1);
    if (changed) push_snap(k+1);
  endtask

  task automatic cyc(input bit r, input bit we, input bit re, input logic [ADDR_W-1:0] a,
                     input logic [31:0] d, input bit fs);
    rst = r; reg_wr_en = we; reg_rd_en = re; reg_addr = a; reg_wr_data = d; frame_sync = fs;
    model_step(cnt, r, we, re, a, d, fs);
    @(posedge clk);
    #1;
    rst = 1'b0; reg_wr_en = 1'b0; reg_rd_en = 1'b0; frame_sync = 1'b0;
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    cyc(1'b0, 1'b1, 1'b0, a, d, 1'b0);
  endtask
  task automatic rd(input logic [ADDR_W-1:0] a);
    cyc(1'b0, 1'b0, 1'b1, a, 32'h0, 1'b0);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, '0, 32'h0, 1'b0);
  endtask
  task automatic fsync();
    cyc(1'b0, 1'b0, 1'b0, '0, 32'h0, 1'b1);
  endtask

  logic [SNAP_W-1:0] dut_snap;
  logic [SNAP_W-1:0] cur_snap = '0;
  assign dut_snap = {armed, ul_car_nco_lsb, ul_car_nco_msb, ul_car_nco_sign,
                     ul_stream_gain_scaler_sign, ul_stream_gain_scaler, ul_stream_gain_fraction,
                     ul_ant_gain_scaler_sign, ul_ant_gain_scaler, ul_ant_gain_fraction,
                     ul_int_delay, ul_frac_delay};

  // Monitor: compares outputs, reads and trigger pulses away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      while (snap_q.size() > 0 && snap_q[0].cyc <= cnt) cur_snap = snap_q.pop_front().v;
      total++;
      if (dut_snap !== cur_snap) begin
        bad++;
        $display("FAIL outputs cyc=%0d got=%h exp=%h", cnt, dut_snap, cur_snap);
      end
      if (rd_q.size() > 0 && rd_q[0].cyc < cnt) begin
        total++; bad++;
        $display("FAIL rd_missing cyc=%0d expected_at=%0d", cnt, rd_q[0].cyc);
        void'(rd_q.pop_front());
      end
      if (reg_rd_valid !== 1'b0) begin
        total++;
        if (reg_rd_valid !== 1'b1 || rd_q.size() == 0 || rd_q[0].cyc != cnt) begin
          bad++;
          $display("FAIL rd_unexpected cyc=%0d valid=%b", cnt, reg_rd_valid);
        end else begin
          rd_item_t it;
          it = rd_q.pop_front();
          if (reg_rd_data !== it.d) begin
            bad++;
            $display("FAIL rd_data cyc=%0d got=%h exp=%h", cnt, reg_rd_data, it.d);
          end
        end
      end
      if (trig_q.size() > 0 && trig_q[0] < cnt) begin
        total++; bad++;
        $display("FAIL trig_missing cyc=%0d expected_at=%0d", cnt, trig_q[0]);
        void'(trig_q.pop_front());
      end
      if (ul_ant_int_frac_delay_trig !== 1'b0) begin
        total++;
        if (trig_q.size() > 0 && trig_q[0] == cnt && ul_ant_int_frac_delay_trig === 1'b1) begin
          void'(trig_q.pop_front());
        end else begin
          bad++;
          $display("FAIL trig_unexpected cyc=%0d got=%b exp=0", cnt, ul_ant_int_frac_delay_trig);
        end
      end
    end
  end

  initial begin
    int op;
    logic [ADDR_W-1:0] a;
    logic [31:0] d;
    bit fs;
    cyc(1'b1, 1'b0, 1'b0, '0, 32'h0, 1'b0);
    chk_en = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, '0, 32'h0, 1'b0);
    idle(2);

    // Reset while armed cancels the commit.
    wr(8'h02, 32'hDEAD_BEEF);
    wr(8'h00, 32'h1);
    idle(1);
    cyc(1'b1, 1'b0, 1'b0, '0, 32'h0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, '0, 32'h0, 1'b0);
    fsync();
    rd(8'h01);
    idle(1);

    // Arm then frame_sync.
    wr(8'h02, 32'h1234_5678);
    wr(8'h04, 32'h0000_01A5);
    wr(8'h00, 32'h1);
    idle(2);
    fsync();
    idle(2);
    rd(8'h01);

    // Delay write + commit_now, then a clean commit_now.
    wr(8'h19, 32'h0023_1234);
    wr(8'h00, 32'h2);
    idle(4);
    wr(8'h00, 32'h2);
    idle(4);

    // Shadow write racing the committing frame_sync.
    wr(8'h10, 32'h0015_AAAA);
    wr(8'h00, 32'h2);
    wr(8'h00, 32'h1);
    cyc(1'b0, 1'b1, 1'b0, 8'h10, 32'hFFE3_5555, 1'b1);
    rd(8'h10);
    idle(1);
    wr(8'h00, 32'h2);
    idle(2);

    // arm+commit_now together, then counter wrap.
    wr(8'h00, 32'h3);
    fsync();
    rd(8'h01);
    for (int i = 0; i < 256; i++) wr(8'h00, 32'h2);
    rd(8'h01);

    // Unmapped reads and trigger merging.
    rd(8'h3F);
    rd(8'h07);
    rd(8'h82);
    cyc(1'b0, 1'b1, 1'b1, 8'h02, 32'h5555_0000, 1'b0);
    wr(8'h1F, 32'hFFFF_FFFF);
    wr(8'h00, 32'h1);
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 32'h4, 1'b1);
    idle(4);
    wr(8'h18, 32'h0001_0001);
    wr(8'h00, 32'h6);
    idle(4);
    wr(8'h1A, 32'h0002_0002);
    wr(8'h00, 32'h2);
    wr(8'h00, 32'h4);
    idle(4);

    for (int i = 0; i < 1500; i++) begin
      op = $urandom_range(0, 9);
      d  = $urandom();
      fs = ($urandom_range(0, 7) == 0);
      a  = ADDR_W'($urandom_range(0, 31));
      if (a == 0) a = 8'h02;
      if ($urandom_range(0, 9) == 0) a = a | 8'h40;
      if ($urandom_range(0, 399) == 0) begin
        cyc(1'b1, 1'b0, 1'b0, '0, 32'h0, 1'b0);
      end else begin
        case (op)
          0, 1, 2, 3, 4: cyc(1'b0, 1'b1, 1'b0, a, d, fs);
          5, 6:          cyc(1'b0, 1'b0, 1'b1, ADDR_W'($urandom_range(0, 255)), d, fs);
          7:             cyc(1'b0, 1'b1, 1'b0, 8'h00, d & 32'h0000_0007 | (d & 32'hF000_0000), fs);
          8:             cyc(1'b0, 1'b0, 1'b0, '0, d, fs);
          default:       cyc(1'b0, 1'b1, 1'b1, ADDR_W'($urandom_range(0, 63)), d, fs);
        endcase
      end
    end
    rd(8'h01);
    idle(6);

    total++;
    if (rd_q.size() != 0) begin
      bad++;
      $display("FAIL rd_leftover got=%0d exp=0", rd_q.size());
    end
    total++;
    if (trig_q.size() != 0) begin
      bad++;
      $display("FAIL trig_leftover got=%0d exp=0", trig_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
